// File: rtl/wishbone_burst_master.sv
// rtl/wishbone_burst_master.sv - Wishbone burst master (read/write bursts of up to MAX_BEATS beats).
// Optional BUS-phase watchdog enabled by defining WB_BURST_TIMEOUT_EN.
module wishbone_burst_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int LEN_W         = $clog2(MAX_BEATS),
    localparam int SEL_W         = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [SEL_W-1:0]  cmd_sel_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              we_o,
    output logic              cyc_o,
    output logic              stb_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    input  logic              err_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        BUS   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic [ADDR_W-1:0]  adr_d;
    logic [DATA_W-1:0]  dat_d, rd_data_d;
    logic [SEL_W-1:0]   sel_d;
    logic               we_d, cyc_d, stb_d, rd_valid_d, done_d, err_d, busy_d;
    logic               wd_expired;

`ifdef WB_BURST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive strobe cycle without a slave response.
    assign wd_expired = (state_q == BUS) && !ack_i && !err_i
                        && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_cnt_q <= '0;
        end else if ((state_q == BUS) && !ack_i && !err_i && !wd_expired) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_q <= '0;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    assign cmd_ready_o = (state_q == IDLE);
    assign wr_ready_o  = (state_q == WDATA);

    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        adr_d      = adr_o;
        dat_d      = dat_o;
        sel_d      = sel_o;
        we_d       = we_o;
        cyc_d      = cyc_o;
        stb_d      = stb_o;
        rd_data_d  = rd_data_o;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    adr_d  = cmd_addr_i;
                    sel_d  = cmd_sel_i;
                    we_d   = cmd_we_i;
                    left_d = cmd_len_i;
                    cyc_d  = 1'b1;
                    if (cmd_we_i) begin
                        stb_d   = 1'b0;
                        state_d = WDATA;
                    end else begin
                        stb_d   = 1'b1;
                        state_d = BUS;
                    end
                end
            end
            WDATA: begin
                cyc_d = 1'b1;
                stb_d = 1'b0;
                if (wr_valid_i) begin
                    dat_d   = wr_data_i;
                    stb_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Error wins over a coincident ack; the erroring beat produces no read data.
                if (err_i || wd_expired) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (ack_i) begin
                    if (!we_o) begin
                        rd_data_d  = dat_i;
                        rd_valid_d = 1'b1;
                    end
                    if (left_q == '0) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        adr_d  = adr_o + ADDR_W'(SEL_W);
                        left_d = left_q - LEN_W'(1);
                        if (we_o) begin
                            stb_d   = 1'b0;
                            state_d = WDATA;
                        end else begin
                            stb_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            left_q     <= '0;
            adr_o      <= '0;
            dat_o      <= '0;
            sel_o      <= '0;
            we_o       <= 1'b0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            adr_o      <= adr_d;
            dat_o      <= dat_d;
            sel_o      <= sel_d;
            we_o       <= we_d;
            cyc_o      <= cyc_d;
            stb_o      <= stb_d;
            rd_data_o  <= rd_data_d;
            rd_valid_o <= rd_valid_d;
            done_o     <= done_d;
            err_o      <= err_d;
            busy_o     <= busy_d;
        end
    end

endmodule

// File: tb/tb_wishbone_burst_master.sv
// tb/tb_wishbone_burst_master.sv - scoreboard bench for wishbone_burst_master.
module tb_wishbone_burst_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [3:0]  cmd_len_i = '0;
    logic [7:0]  cmd_sel_i = '0;
    logic [63:0] wr_data_i = '0;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [63:0] rd_data_o;
    logic        rd_valid_o, done_o, err_o, busy_o;
    logic [31:0] adr_o;
    logic [63:0] dat_o;
    logic [7:0]  sel_o;
    logic        we_o, cyc_o, stb_o;
    logic [63:0] dat_i = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;

    wishbone_burst_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .err_o(err_o),
        .busy_o(busy_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [7:0]  sel;
        logic [63:0] dat;
    } beat_t;

    beat_t       beat_q[$];
    logic [63:0] rd_q[$];
    logic        done_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    int wait_n     = 0;
    int err_beat   = -1;
    int beat_idx   = 0;
    int wcnt       = 0;
    bit hold       = 1'b0;
    int stb_cycles = 0;

    bit in_wr      = 1'b0;
    int cyc_gaps   = 0;
    int stb_in_wd  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] rdata(input logic [31:0] a);
        return {~a, a};
    endfunction

    function automatic beat_t mk(input logic [31:0] a, input logic we, input logic [7:0] sel,
                                 input logic [63:0] d);
        beat_t b;
        b.adr = a; b.we = we; b.sel = sel; b.dat = d;
        return b;
    endfunction

    // Slave model: also checks each presented beat against the expected-beat queue.
    always @(negedge clk_i) begin
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = '0;
        if (cyc_o && stb_o) begin
            stb_cycles++;
            if (!hold) begin
                if (wcnt < wait_n) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    if (beat_q.size() == 0) begin
                        chk("beat_unexpected", {32'h0, adr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        beat_t b;
                        b = beat_q.pop_front();
                        chk("beat_adr", {32'h0, adr_o}, {32'h0, b.adr});
                        chk("beat_we", {63'h0, we_o}, {63'h0, b.we});
                        chk("beat_sel", {56'h0, sel_o}, {56'h0, b.sel});
                        if (b.we) chk("beat_dat", dat_o, b.dat);
                    end
                    ack_i = 1'b1;
                    if (beat_idx == err_beat) err_i = 1'b1;
                    dat_i = rdata(adr_o);
                    beat_idx++;
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor for read strobes and burst completion.
    always @(negedge clk_i) begin
        if (rd_valid_o) begin
            if (rd_q.size() == 0) chk("rd_unexpected", rd_data_o, 64'hX);
            else chk("rd_data", rd_data_o, rd_q.pop_front());
        end
        if (done_o) begin
            done_cnt++;
            if (done_q.size() == 0) chk("done_unexpected", {63'h0, done_o}, 64'h0);
            else chk("done_err", {63'h0, err_o}, {63'h0, done_q.pop_front()});
            chk("done_cyc_stb_low", {62'h0, cyc_o, stb_o}, 64'h0);
        end
        if (err_o && !done_o) chk("err_without_done", {63'h0, err_o}, 64'h0);
        if (in_wr) begin
            if (busy_o && !cyc_o) cyc_gaps++;
            if (wr_ready_o && stb_o) stb_in_wd++;
        end
    end

    task automatic cfg(input int w, input int eb, input bit h);
        wait_n = w; err_beat = eb; hold = h; beat_idx = 0;
    endtask

    task automatic issue_cmd(input logic we, input logic [31:0] a, input logic [3:0] len,
                             input logic [7:0] sel);
        int n = 0;
        cmd_we_i = we; cmd_addr_i = a; cmd_len_i = len; cmd_sel_i = sel; cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk("cmd_accept_timeout", {63'h0, cmd_ready_o}, 64'h1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_wdata(input logic [63:0] d, input int delay);
        int n = 0;
        while (!wr_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk("wr_ready_timeout", {63'h0, wr_ready_o}, 64'h1);
        repeat (delay) @(negedge clk_i);
        wr_data_i = d; wr_valid_i = 1'b1;
        @(negedge clk_i);
        wr_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt), 64'(target));
        @(negedge clk_i);
        chk({name, "_queues_empty"}, 64'(beat_q.size() + rd_q.size() + done_q.size()), 64'h0);
    endtask

    initial begin
        int tgt;
        int saved;
        repeat (2) @(negedge clk_i);
        chk("rst_adr", {32'h0, adr_o}, 64'h0);
        chk("rst_dat", dat_o, 64'h0);
        chk("rst_sel", {56'h0, sel_o}, 64'h0);
        chk("rst_rd_data", rd_data_o, 64'h0);
        chk("rst_ctrl", {55'h0, cyc_o, stb_o, we_o, rd_valid_o, done_o, err_o, busy_o,
                         cmd_ready_o, wr_ready_o}, 64'h2);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Read 0x100 len 3, one wait state per beat
        cfg(1, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            beat_q.push_back(mk(32'h100 + 32'(8 * i), 1'b0, 8'hFF, 64'h0));
            rd_q.push_back(rdata(32'h100 + 32'(8 * i)));
        end
        done_q.push_back(1'b0);
        issue_cmd(1'b0, 32'h100, 4'd3, 8'hFF);
        wait_done("read4", 1);

        // Write len 1 with data delayed three cycles per beat
        cfg(0, -1, 1'b0);
        cyc_gaps = 0; stb_in_wd = 0; in_wr = 1'b1;
        beat_q.push_back(mk(32'h2000, 1'b1, 8'h0F, 64'h1111_2222_3333_4444));
        beat_q.push_back(mk(32'h2008, 1'b1, 8'h0F, 64'h5555_6666_7777_8888));
        done_q.push_back(1'b0);
        issue_cmd(1'b1, 32'h2000, 4'd1, 8'h0F);
        send_wdata(64'h1111_2222_3333_4444, 3);
        send_wdata(64'h5555_6666_7777_8888, 3);
        wait_done("write2", 2);
        in_wr = 1'b0;
        chk("write_cyc_continuous", 64'(cyc_gaps), 64'h0);
        chk("write_stb_low_in_wdata", 64'(stb_in_wd), 64'h0);

        // Read len 7, err_i together with ack_i on the third beat
        cfg(0, 2, 1'b0);
        beat_q.push_back(mk(32'h400, 1'b0, 8'hFF, 64'h0));
        beat_q.push_back(mk(32'h408, 1'b0, 8'hFF, 64'h0));
        beat_q.push_back(mk(32'h410, 1'b0, 8'hFF, 64'h0));
        rd_q.push_back(rdata(32'h400));
        rd_q.push_back(rdata(32'h408));
        done_q.push_back(1'b1);
        issue_cmd(1'b0, 32'h400, 4'd7, 8'hFF);
        wait_done("read_err", 3);

        // Address wrap
        cfg(0, -1, 1'b0);
        beat_q.push_back(mk(32'hFFFF_FFF8, 1'b0, 8'hFF, 64'h0));
        beat_q.push_back(mk(32'h0000_0000, 1'b0, 8'hFF, 64'h0));
        rd_q.push_back(rdata(32'hFFFF_FFF8));
        rd_q.push_back(rdata(32'h0000_0000));
        done_q.push_back(1'b0);
        issue_cmd(1'b0, 32'hFFFF_FFF8, 4'd1, 8'hFF);
        wait_done("wrap", 4);

        // Single-beat write, two wait states
        cfg(2, -1, 1'b0);
        beat_q.push_back(mk(32'h50, 1'b1, 8'h81, 64'hA5A5_5A5A_0F0F_F0F0));
        done_q.push_back(1'b0);
        issue_cmd(1'b1, 32'h50, 4'd0, 8'h81);
        send_wdata(64'hA5A5_5A5A_0F0F_F0F0, 0);
        wait_done("write1", 5);

        // Second command held during the first burst; accepted in the done_o cycle
        cfg(0, -1, 1'b0);
        beat_q.push_back(mk(32'h3000, 1'b0, 8'hFF, 64'h0));
        beat_q.push_back(mk(32'h3100, 1'b0, 8'h3C, 64'h0));
        rd_q.push_back(rdata(32'h3000));
        rd_q.push_back(rdata(32'h3100));
        done_q.push_back(1'b0);
        done_q.push_back(1'b0);
        cmd_we_i = 1'b0; cmd_addr_i = 32'h3000; cmd_len_i = 4'd0; cmd_sel_i = 8'hFF;
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_addr_i = 32'h3100; cmd_sel_i = 8'h3C;
        tgt = 0;
        while (!cmd_ready_o && tgt < 100) begin
            @(negedge clk_i);
            tgt++;
        end
        chk("b2b_accept_with_done", {63'h0, done_o}, 64'h1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        wait_done("b2b", 7);

        // Reset in the middle of a stalled burst
        cfg(0, -1, 1'b1);
        saved = done_cnt;
        issue_cmd(1'b0, 32'h800, 4'd7, 8'hFF);
        repeat (4) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("rst_async_cyc_stb", {62'h0, cyc_o, stb_o}, 64'h0);
        chk("rst_async_adr_busy", {31'h0, busy_o, adr_o}, 64'h0);
        @(negedge clk_i);
        hold = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_no_done", 64'(done_cnt), 64'(saved));
        cfg(0, -1, 1'b0);
        beat_q.push_back(mk(32'h900, 1'b0, 8'hFF, 64'h0));
        beat_q.push_back(mk(32'h908, 1'b0, 8'hFF, 64'h0));
        rd_q.push_back(rdata(32'h900));
        rd_q.push_back(rdata(32'h908));
        done_q.push_back(1'b0);
        issue_cmd(1'b0, 32'h900, 4'd1, 8'hFF);
        wait_done("after_rst", saved + 1);

        // Silent slave
        cfg(0, -1, 1'b1);
        stb_cycles = 0;
`ifdef WB_BURST_TIMEOUT_EN
        done_q.push_back(1'b1);
        issue_cmd(1'b0, 32'hA00, 4'd2, 8'hFF);
        wait_done("timeout", saved + 2);
        chk("timeout_stb_cycles", 64'(stb_cycles), 64'd8);
        hold = 1'b0;
`else
        issue_cmd(1'b0, 32'hA00, 4'd2, 8'hFF);
        repeat (1000) @(negedge clk_i);
        chk("stall_stb_high", {61'h0, cyc_o, stb_o, busy_o}, 64'h7);
        chk("stall_no_done", 64'(done_cnt), 64'(saved + 1));
        rst_i = 1'b0;
        @(negedge clk_i);
        hold = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
